// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: streaming 3x3 Sobel edge magnitude with threshold and bypass
module sobel_edge_filter #(
  parameter int          IMG_WIDTH = 640,
  parameter logic [11:0] THRESH    = 12'h200
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [11:0] iGray,
  input  logic        iDVAL,
  input  logic        iFVAL,
  input  logic        iEnable,
  input  logic        iThreshEn,
  output logic [11:0] oRed,
  output logic [11:0] oGreen,
  output logic [11:0] oBlue,
  output logic        oDVAL
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  logic [XW-1:0] x_q, x_d, px;
  logic [10:0] y_q, y_d, py;
  logic [11:0] lb1_q [IMG_WIDTH];
  logic [11:0] lb2_q [IMG_WIDTH];
  logic [11:0] win_q [3][3];
  logic [11:0] win_d [3][3];
  logic signed [14:0] gx_q, gx_d, gy_q, gy_d;
  logic border_q, border_d;
  logic dval_q, odval_q;
  logic [11:0] gray_q, pix_q, pix_d;
  logic [14:0] ax, ay;
  logic [15:0] mag;
  logic [11:0] sat, edge_v;

  function automatic logic signed [14:0] s(input logic [11:0] v);
    return $signed({3'b000, v});
  endfunction

  // Pixel position; a low frame-valid forces position (0,0) for the current pixel and the next
  always_comb begin
    px = iFVAL ? x_q : '0;
    py = iFVAL ? y_q : '0;
    x_d = !iFVAL ? '0 : !iDVAL ? x_q : (x_q == X_LAST) ? '0 : x_q + 1'b1;
    y_d = (iFVAL && iDVAL && x_q == X_LAST && y_q != 11'h7FF) ? y_q + 11'd1 : py;
    border_d = (px < XW'(2)) || (py < 11'd2);
  end

  // Next window and its gradients, so Gx/Gy land one cycle after the accept
  always_comb begin
    win_d = win_q;
    if (iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_q[px];
      win_d[1][2] = lb1_q[px];
      win_d[2][2] = iGray;
    end
    gx_d = (s(win_d[0][2]) + (s(win_d[1][2]) <<< 1) + s(win_d[2][2]))
         - (s(win_d[0][0]) + (s(win_d[1][0]) <<< 1) + s(win_d[2][0]));
    gy_d = (s(win_d[2][0]) + (s(win_d[2][1]) <<< 1) + s(win_d[2][2]))
         - (s(win_d[0][0]) + (s(win_d[0][1]) <<< 1) + s(win_d[0][2]));
  end

  // Magnitude, saturation, border mask, threshold and bypass select
  always_comb begin
    ax = gx_q[14] ? -gx_q : gx_q;
    ay = gy_q[14] ? -gy_q : gy_q;
    mag = {1'b0, ax} + {1'b0, ay};
    sat = (mag > 16'd4095) ? 12'hFFF : mag[11:0];
    edge_v = border_q ? 12'h000 : !iThreshEn ? sat : (sat >= THRESH) ? 12'hFFF : 12'h000;
    pix_d = iEnable ? edge_v : gray_q;
  end

  // Line buffers: read-before-write shift of the column down one row
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb2_q[px] <= lb1_q[px];
      lb1_q[px] <= iGray;
    end
  end

  // Position, window and two pipeline stages
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_q      <= '0;
      y_q      <= '0;
      win_q    <= '{default: 12'h000};
      gx_q     <= '0;
      gy_q     <= '0;
      border_q <= 1'b1;
      gray_q   <= '0;
      dval_q   <= 1'b0;
      pix_q    <= '0;
      odval_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      win_q    <= win_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      border_q <= border_d;
      gray_q   <= iGray;
      dval_q   <= iDVAL;
      pix_q    <= pix_d;
      odval_q  <= dval_q;
    end
  end

  assign oRed   = pix_q;
  assign oGreen = pix_q;
  assign oBlue  = pix_q;
  assign oDVAL  = odval_q;
endmodule

// File: tb/tb_sobel_edge_filter.sv
// tb_sobel_edge_filter: randomized and directed checks against an image-level Sobel model
module tb_sobel_edge_filter;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [11:0] gray = '0;
  logic dval = 1'b0, fval = 1'b0, en = 1'b1, th = 1'b0;
  logic [11:0] o_r, o_g, o_b;
  logic o_dval;
  int checks = 0, errors = 0;
  int mx, my, cx, cy, nout = 0;
  logic [11:0] img [3][W];
  logic d1 = 1'b0, d2 = 1'b0;
  logic [11:0] s1 = '0, g1 = '0, e2 = '0;
  logic [11:0] out_log [256];

  sobel_edge_filter #(.IMG_WIDTH(W), .THRESH(12'h200)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iGray(gray), .iDVAL(dval), .iFVAL(fval),
    .iEnable(en), .iThreshEn(th), .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oDVAL(o_dval)
  );

  always #5 clk = ~clk;

  // Sobel over the stored image, centre (x-1,y-1), saturated to 4095
  function automatic int sobel(input int x, input int y);
    int p [3][3];
    int gx, gy, m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(img[(y - 2 + r) % 3][x - 2 + c]);
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return m > 4095 ? 4095 : m;
  endfunction

  // Reference: image rows modulo 3, result finalised with the controls seen one cycle after accept
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 1'b0; d2 = 1'b0; mx = 0; my = 0;
    end else begin
      d2 = d1;
      e2 = !en ? g1 : !th ? s1 : (s1 >= 12'h200 ? 12'hFFF : 12'h000);
      d1 = dval;
      if (dval) begin
        cx = fval ? mx : 0;
        cy = fval ? my : 0;
        img[cy % 3][cx] = gray;
        s1 = (cx < 2 || cy < 2) ? 12'h000 : 12'(sobel(cx, cy));
        g1 = gray;
        if (fval) begin
          mx++;
          if (mx == W) begin
            mx = 0;
            if (my < 2047) my++;
          end
        end
      end
      if (!fval) begin
        mx = 0; my = 0;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (o_dval !== d2) begin
        errors++;
        $display("FAIL odval: got %b want %b at %0t", o_dval, d2, $time);
      end
      if (d2) begin
        checks++;
        if (o_r !== e2 || o_g !== e2 || o_b !== e2) begin
          errors++;
          $display("FAIL pixel: got r=%h g=%h b=%h want %h at %0t", o_r, o_g, o_b, e2, $time);
        end
      end
      if (o_dval) begin
        out_log[nout % 256] = o_r;
        nout++;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step(input logic [11:0] g, input logic dv, input logic fv);
    @(posedge clk);
    #1;
    gray = g; dval = dv; fval = fv;
  endtask

  task automatic idle(input int n);
    repeat (n) step(12'h000, 1'b0, 1'b0);
  endtask

  function automatic logic [11:0] pat(input int kind, input int x);
    case (kind)
      0: return 12'h100;
      1: return x >= 4 ? 12'h100 : 12'h000;
      default: return x >= 4 ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic frame(input int kind, input int rows);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < W; x++)
        step(pat(kind, x), 1'b1, 1'b1);
    idle(4);
  endtask

  int nz;
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_dval", int'(o_dval), 0);
    chk("reset_pix", int'(o_r), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    nout = 0;
    frame(0, 4);
    chk("flat_count", nout, 32);
    nz = 0;
    for (int i = 0; i < 32; i++) if (out_log[i] != 0) nz++;
    chk("flat_nonzero", nz, 0);

    nout = 0;
    frame(1, 6);
    chk("step_count", nout, 48);
    chk("step_y2x4", int'(out_log[2 * W + 4]), 12'h400);
    chk("step_y2x5", int'(out_log[2 * W + 5]), 12'h400);
    chk("step_y2x3", int'(out_log[2 * W + 3]), 0);
    chk("step_y2x6", int'(out_log[2 * W + 6]), 0);
    chk("step_y5x4", int'(out_log[5 * W + 4]), 12'h400);
    chk("step_y1x4", int'(out_log[1 * W + 4]), 0);

    nout = 0;
    frame(2, 6);
    chk("sat_y3x4", int'(out_log[3 * W + 4]), 12'hFFF);
    th = 1'b1;
    nout = 0;
    frame(2, 6);
    chk("thr_y3x5", int'(out_log[3 * W + 5]), 12'hFFF);
    chk("thr_y3x6", int'(out_log[3 * W + 6]), 0);
    th = 1'b0;

    en = 1'b0;
    nout = 0;
    for (int i = 1; i <= 20; i++) begin
      step(12'(i), 1'b1, 1'b1);
      if (i % 3 == 0) step(12'h000, 1'b0, 1'b1);
    end
    idle(4);
    chk("bypass_count", nout, 20);
    for (int i = 0; i < 20; i++) chk("bypass_ramp", int'(out_log[i]), i + 1);
    en = 1'b1;

    nout = 0;
    frame(1, 3);
    frame(1, 3);
    chk("restart_y1x4", int'(out_log[24 + 1 * W + 4]), 0);
    chk("restart_y2x4", int'(out_log[24 + 2 * W + 4]), 12'h400);

    step(12'h100, 1'b1, 1'b0);
    idle(3);

    for (int i = 0; i < 5; i++) step(12'h100, 1'b1, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_dval", int'(o_dval), 0);
    chk("midreset_pix", int'(o_r), 0);
    idle(2);
    rst_n = 1'b1;
    nout = 0;
    frame(1, 3);
    chk("postreset_count", nout, 24);

    for (int f = 0; f < 8; f++) begin
      int rows, last;
      rows = $urandom_range(2, 5);
      last = $urandom_range(1, W);
      for (int y = 0; y < rows; y++)
        for (int x = 0; x < (y == rows - 1 ? last : W); x++) begin
          while ($urandom_range(0, 3) == 0) begin
            en = 1'($urandom); th = 1'($urandom);
            step(12'($urandom), 1'b0, 1'b1);
          end
          en = ($urandom_range(0, 5) != 0); th = 1'($urandom);
          step(($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 4095)) : 12'h000, 1'b1, 1'b1);
        end
      if (f % 2 == 0) step(12'($urandom), 1'b1, 1'b0);
      idle($urandom_range(1, 4));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
